// File: rtl/mig_ui_pkg.sv
// Shared MIG user-interface command encodings and arbiter state type.
package mig_ui_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    CAL    = 2'd0,
    GNT_RD = 2'd1,
    GNT_WR = 2'd2,
    TURN   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter that saturates at MAX and never wraps below zero.
module credit_counter #(
  parameter int MAX = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(MAX+1)-1:0]   count,
  output logic                       full
);

  localparam int W = $clog2(MAX + 1);

  assign full = (count == W'(MAX));

  // Count up on inc, down on dec; simultaneous inc and dec cancel out.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A return with nothing in flight points at a broken downstream.
  underflow_a : assert property (@(posedge clk_in) disable iff (rst_in)
    !(dec && !inc && count == '0));

endmodule

// File: rtl/mig_cmd_arbiter.sv
// Arbitrates the single MIG UI command port between a write and a read stream
// with bounded bursts, a one-cycle turnaround, starvation relief and read credits.
module mig_cmd_arbiter
  import mig_ui_pkg::*;
#(
  parameter int WR_BURST     = 16,
  parameter int RD_BURST     = 16,
  parameter int MAX_RD_OUT   = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              init_calib_complete,
  input  logic                              wr_req_valid,
  output logic                              wr_req_ready,
  input  logic [26:0]                       wr_req_addr,
  input  logic [127:0]                      wr_req_data,
  input  logic                              rd_req_valid,
  output logic                              rd_req_ready,
  input  logic [26:0]                       rd_req_addr,
  output logic [26:0]                       app_addr,
  output logic [2:0]                        app_cmd,
  output logic                              app_en,
  output logic [127:0]                      app_wdf_data,
  output logic                              app_wdf_wren,
  output logic                              app_wdf_end,
  input  logic                              app_rdy,
  input  logic                              app_wdf_rdy,
  input  logic                              app_rd_data_valid,
  output logic [$clog2(MAX_RD_OUT+1)-1:0]   rd_outstanding,
  output logic [1:0]                        state_out
);

  localparam int BURST_MAX = (WR_BURST > RD_BURST) ? WR_BURST : RD_BURST;
  localparam int BURST_W   = $clog2(BURST_MAX + 1);
  localparam int STARVE_W  = $clog2(STARVE_LIMIT + 1);

  arb_state_t           state, state_nxt;
  logic                 prev_rd;
  logic [BURST_W-1:0]   burst_cnt, burst_limit;
  logic [STARVE_W-1:0]  starve_cnt;
  logic                 rd_full, rd_eligible, wr_eligible;
  logic                 is_rd, is_wr, granted;
  logic                 rd_issue, wr_issue, cmd_accept;
  logic                 own_eligible, other_eligible, burst_hit, switch_req;

  assign is_rd   = (state == GNT_RD);
  assign is_wr   = (state == GNT_WR);
  assign granted = is_rd || is_wr;

  assign wr_eligible = wr_req_valid;
  assign rd_eligible = rd_req_valid && !rd_full;

  assign rd_issue   = is_rd && rd_eligible && app_rdy;
  assign wr_issue   = is_wr && wr_req_valid && app_rdy && app_wdf_rdy;
  assign cmd_accept = rd_issue || wr_issue;

  assign own_eligible   = is_rd ? rd_eligible : wr_eligible;
  assign other_eligible = is_rd ? wr_eligible : rd_eligible;
  assign burst_limit    = is_rd ? BURST_W'(RD_BURST) : BURST_W'(WR_BURST);

  // The limit includes the command accepted this cycle, so a grant hands over
  // straight after its last allowed command instead of idling one extra cycle.
  assign burst_hit  = (burst_cnt == burst_limit) ||
                      (cmd_accept && burst_cnt == burst_limit - 1'b1);
  assign switch_req = granted && other_eligible &&
                      (burst_hit || !own_eligible || starve_cnt == STARVE_W'(STARVE_LIMIT));

  assign state_out = state;

  credit_counter #(.MAX(MAX_RD_OUT)) u_rd_credit (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (rd_issue),
    .dec    (app_rd_data_valid),
    .count  (rd_outstanding),
    .full   (rd_full)
  );

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= CAL;
    else        state <= state_nxt;
  end

  // Burst, starvation and last-direction bookkeeping.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      burst_cnt  <= '0;
      starve_cnt <= '0;
      prev_rd    <= 1'b0;
    end else begin
      if (!granted)                                   burst_cnt <= '0;
      else if (cmd_accept && burst_cnt != burst_limit) burst_cnt <= burst_cnt + 1'b1;

      if (state == TURN)
        starve_cnt <= '0;
      else if (granted && other_eligible && starve_cnt != STARVE_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      if (is_rd)      prev_rd <= 1'b1;
      else if (is_wr) prev_rd <= 1'b0;
    end
  end

  // Next state and the UI port mux; CAL and TURN leave everything idle.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    app_addr     = '0;
    app_cmd      = '0;
    app_en       = 1'b0;
    app_wdf_data = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wr_req_ready = 1'b0;
    rd_req_ready = 1'b0;
    case (state)
      CAL: begin
        if (init_calib_complete) state_nxt = GNT_RD;
      end
      GNT_RD: begin
        app_cmd      = CMD_READ;
        app_addr     = rd_req_addr;
        app_en       = rd_issue;
        rd_req_ready = app_rdy && !rd_full;
        if (switch_req) state_nxt = TURN;
      end
      GNT_WR: begin
        app_cmd      = CMD_WRITE;
        app_addr     = wr_req_addr;
        app_wdf_data = wr_req_data;
        app_en       = wr_issue;
        app_wdf_wren = wr_issue;
        app_wdf_end  = wr_issue;
        wr_req_ready = app_rdy && app_wdf_rdy;
        if (switch_req) state_nxt = TURN;
      end
      TURN: begin
        state_nxt = prev_rd ? GNT_WR : GNT_RD;
      end
      default: state_nxt = CAL;
    endcase
  end

endmodule

// File: tb/tb_mig_cmd_arbiter.sv
// Directed bench for mig_cmd_arbiter: calibration, burst alternation, read
// credits, starvation relief, simultaneous issue/return and async reset.
module tb_mig_cmd_arbiter;
  import mig_ui_pkg::*;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         init_calib_complete;
  logic         wr_req_valid, wr_req_ready;
  logic [26:0]  wr_req_addr;
  logic [127:0] wr_req_data;
  logic         rd_req_valid, rd_req_ready;
  logic [26:0]  rd_req_addr;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren, app_wdf_end;
  logic         app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [3:0]   rd_outstanding;
  logic [1:0]   state_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   ret_en;
  logic ret_p1, issued;
  int   cyc, cmds, cnt;

  mig_cmd_arbiter dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .init_calib_complete (init_calib_complete),
    .wr_req_valid        (wr_req_valid),
    .wr_req_ready        (wr_req_ready),
    .wr_req_addr         (wr_req_addr),
    .wr_req_data         (wr_req_data),
    .rd_req_valid        (rd_req_valid),
    .rd_req_ready        (rd_req_ready),
    .rd_req_addr         (rd_req_addr),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data_valid   (app_rd_data_valid),
    .rd_outstanding      (rd_outstanding),
    .state_out           (state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; when enabled, reads come back two cycles after issue.
  task automatic step();
    #1;
    issued = app_en && (app_cmd == CMD_READ);
    @(posedge clk_in);
    #1;
    if (ret_en) begin
      app_rd_data_valid = ret_p1;
      ret_p1            = issued;
    end
  endtask

  // Stay while state_out == st, counting cycles and issued commands (bounded).
  task automatic run_state(input logic [1:0] st, output int c, output int k);
    c = 0;
    k = 0;
    while (state_out == st && c < 300) begin
      c++;
      if (app_en) k++;
      step();
    end
  endtask

  task automatic do_reset();
    rst_in              = 1'b1;
    init_calib_complete = 1'b0;
    wr_req_valid        = 1'b0;
    rd_req_valid        = 1'b0;
    app_rd_data_valid   = 1'b0;
    ret_en              = 1'b0;
    ret_p1              = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_req_addr = 27'h7654321;
    rd_req_addr = 27'h0123456;
    wr_req_data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    rst_in      = 1'b1;
    init_calib_complete = 1'b0;
    wr_req_valid = 1'b1;
    rd_req_valid = 1'b1;
    app_rd_data_valid = 1'b0;
    ret_en = 1'b0;
    ret_p1 = 1'b0;
    #1;
    check("rst_state", state_out, 2'd0);
    check("rst_app_en", app_en, 1'b0);
    check("rst_readys", {wr_req_ready, rd_req_ready}, 2'b00);
    check("rst_outstanding", rd_outstanding, 4'd0);

    // Calibration hold, then first read grant.
    do_reset();
    wr_req_valid = 1'b1;
    rd_req_valid = 1'b1;
    ret_en       = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (app_en) cnt++;
      step();
    end
    check("cal_app_en_count", cnt, 0);
    check("cal_state", state_out, 2'd0);
    init_calib_complete = 1'b1;
    step();
    check("gnt_rd_state", state_out, 2'd1);
    check("gnt_rd_app_en", app_en, 1'b1);
    check("gnt_rd_cmd", app_cmd, CMD_READ);
    check("gnt_rd_addr", app_addr, 27'h0123456);
    check("gnt_rd_readys", {wr_req_ready, rd_req_ready, app_wdf_wren}, 3'b010);

    // Burst alternation: 16 reads, TURN, 16 writes, TURN, 16 reads.
    run_state(2'd1, cyc, cmds);
    check("rd_burst1_cycles", cyc, 16);
    check("rd_burst1_cmds", cmds, 16);
    check("turn1_state", state_out, 2'd3);
    run_state(2'd3, cyc, cmds);
    check("turn1_cycles", cyc, 1);
    check("gnt_wr_state", state_out, 2'd2);
    check("gnt_wr_cmd", app_cmd, CMD_WRITE);
    check("gnt_wr_addr", app_addr, 27'h7654321);
    check("gnt_wr_data", app_wdf_data, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    check("gnt_wr_strobes", {app_en, app_wdf_wren, app_wdf_end, wr_req_ready, rd_req_ready}, 5'b11110);
    run_state(2'd2, cyc, cmds);
    check("wr_burst_cycles", cyc, 16);
    check("wr_burst_cmds", cmds, 16);
    run_state(2'd3, cyc, cmds);
    check("turn2_cycles", cyc, 1);
    run_state(2'd1, cyc, cmds);
    check("rd_burst2_cmds", cmds, 16);

    // Starvation: writes blocked by app_wdf_rdy while reads wait.
    check("turn3_state", state_out, 2'd3);
    app_wdf_rdy = 1'b0;
    run_state(2'd3, cyc, cmds);
    check("starve_wr_ready", wr_req_ready, 1'b0);
    run_state(2'd2, cyc, cmds);
    check("starve_wr_cycles", cyc, 65);
    check("starve_wr_cmds", cmds, 0);
    check("starve_turn", state_out, 2'd3);
    step();
    check("starve_rd_resume", {state_out, app_en}, {2'd1, 1'b1});
    app_wdf_rdy = 1'b1;

    // Async reset asserted mid write burst.
    run_state(2'd1, cyc, cmds);
    check("rd_burst3_cmds", cmds, 16);
    run_state(2'd3, cyc, cmds);
    step();
    step();
    check("midwr_active", {state_out, app_en, app_wdf_wren}, {2'd2, 2'b11});
    #2;
    rst_in = 1'b1;
    #1;
    check("midwr_rst_state", state_out, 2'd0);
    check("midwr_rst_strobes", {app_en, app_wdf_wren, app_wdf_end, wr_req_ready, rd_req_ready}, 5'b00000);
    check("midwr_rst_bus", {app_cmd, app_addr, app_wdf_data}, 158'd0);

    // Credit limit with read-only traffic and no returns.
    do_reset();
    init_calib_complete = 1'b1;
    rd_req_valid = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (app_en) cnt++;
      step();
    end
    check("credit_reads", cnt, 8);
    check("credit_outstanding", rd_outstanding, 4'd8);
    check("credit_block", {state_out, rd_req_ready, app_en}, {2'd1, 2'b00});
    app_rd_data_valid = 1'b1;
    #1;
    check("credit_full_no_issue", app_en, 1'b0);
    step();
    app_rd_data_valid = 1'b0;
    #1;
    check("credit_after_return", rd_outstanding, 4'd7);
    check("credit_reissue", app_en, 1'b1);
    step();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (app_en) cnt++;
      step();
    end
    check("credit_refull_extra", cnt, 0);
    check("credit_refull", rd_outstanding, 4'd8);
    rst_in = 1'b1;
    #1;
    check("credit_rst_drop", rd_outstanding, 4'd0);

    // Simultaneous issue and return at five outstanding.
    do_reset();
    init_calib_complete = 1'b1;
    rd_req_valid = 1'b1;
    step();
    repeat (5) step();
    rd_req_valid = 1'b0;
    #1;
    check("sim_pre", rd_outstanding, 4'd5);
    rd_req_valid      = 1'b1;
    app_rd_data_valid = 1'b1;
    #1;
    check("sim_issue", app_en, 1'b1);
    step();
    rd_req_valid      = 1'b0;
    app_rd_data_valid = 1'b0;
    #1;
    check("sim_post", rd_outstanding, 4'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
